// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address helper for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWAP_OUT   = 2'd1,
    SWAP_IN    = 2'd2,
    SWAP_IN_OK = 2'd3
  } dcache_state_e;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_SET_ADDR_LEN  = 2;
  localparam int DEF_WORDS_PER_LINE = 1 << DEF_LINE_ADDR_LEN;
  localparam int DEF_SET_CNT        = 1 << DEF_SET_ADDR_LEN;
  localparam int DEF_TAG_ADDR_LEN   = 32 - 2 - DEF_LINE_ADDR_LEN - DEF_SET_ADDR_LEN;

  // Byte address of a word within a line: {tag, set, word, 2'b00}.
  function automatic logic [31:0] mem_word_addr(input logic [31:0] tag,
                                                input logic [31:0] set,
                                                input logic [31:0] word,
                                                input int          set_len,
                                                input int          line_len);
    return (tag << (set_len + line_len + 2)) | (set << (line_len + 2)) | (word << 2);
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// Age-counter update and victim selection for one set of the data cache.
module dcache_lru #(
  parameter int WAY_CNT = 2,
  parameter int AGE_W   = 1,
  parameter int WAY_W   = 1
) (
  input  logic [WAY_CNT*AGE_W-1:0] age_i,
  input  logic [WAY_CNT-1:0]       valid_i,
  input  logic [WAY_W-1:0]         way_i,
  output logic [WAY_CNT*AGE_W-1:0] age_o,
  output logic [WAY_W-1:0]         victim_o
);

  logic [AGE_W-1:0] old_age;
  logic [AGE_W-1:0] max_age;
  logic             found;

  // An invalid way being filled counts as the oldest, so every valid way ages by one.
  always_comb begin
    old_age = valid_i[way_i] ? age_i[way_i*AGE_W +: AGE_W] : AGE_W'(WAY_CNT - 1);
    age_o   = age_i;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (WAY_W'(w) == way_i) begin
        age_o[w*AGE_W +: AGE_W] = '0;
      end else if (valid_i[w] && (age_i[w*AGE_W +: AGE_W] < old_age)) begin
        age_o[w*AGE_W +: AGE_W] = age_i[w*AGE_W +: AGE_W] + 1'b1;
      end
    end
  end

  always_comb begin
    found    = 1'b0;
    victim_o = '0;
    max_age  = age_i[0 +: AGE_W];
    for (int w = 0; w < WAY_CNT; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 1; w < WAY_CNT; w++) begin
        if (age_i[w*AGE_W +: AGE_W] > max_age) begin
          max_age  = age_i[w*AGE_W +: AGE_W];
          victim_o = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/dcache_setassoc.sv
// N-way set-associative write-back, write-allocate data cache with a word-serial memory port.
module dcache_setassoc
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
  parameter int WAY_CNT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [3:0]  wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int WORDS        = 1 << LINE_ADDR_LEN;
  localparam int SETS         = 1 << SET_ADDR_LEN;
  localparam int AGE_W        = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
  localparam int WAY_W        = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
  localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = '1;

  logic [31:0]             data_q  [WAY_CNT][SETS][WORDS];
  logic [TAG_ADDR_LEN-1:0] tag_q   [WAY_CNT][SETS];
  logic [WAY_CNT-1:0]      valid_q [SETS];
  logic [WAY_CNT-1:0]      dirty_q [SETS];
  logic [WAY_CNT*AGE_W-1:0] age_q  [SETS];

  dcache_state_e            state_q;
  logic [LINE_ADDR_LEN-1:0] cnt_q;
  logic [WAY_W-1:0]         victim_q;
  logic [TAG_ADDR_LEN-1:0]  ltag_q;
  logic [SET_ADDR_LEN-1:0]  lset_q;

  logic [TAG_ADDR_LEN-1:0]  req_tag;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [LINE_ADDR_LEN-1:0] req_word;
  logic [LINE_ADDR_LEN-1:0] cnt_d;
  logic                     req, hit, store;
  logic [WAY_CNT-1:0]       match;
  logic [WAY_W-1:0]         hit_way, vic_way, lru_way;
  logic [SET_ADDR_LEN-1:0]  lru_set;
  logic [WAY_CNT*AGE_W-1:0] lru_age;
  logic                     lru_upd;
  logic [1:0]               unused_addr_bits;

  assign req_tag          = addr[31 -: TAG_ADDR_LEN];
  assign req_set          = addr[31-TAG_ADDR_LEN -: SET_ADDR_LEN];
  assign req_word         = addr[2 +: LINE_ADDR_LEN];
  assign unused_addr_bits = addr[1:0];
  assign cnt_d            = cnt_q + 1'b1;

  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (valid_q[req_set][w] && (tag_q[w][req_set] == req_tag)) begin
        match[w] = 1'b1;
        hit_way  = WAY_W'(w);
      end
    end
  end

  assign store   = |wr_req;
  assign req     = rd_req | store;
  assign hit     = req && (state_q == IDLE) && $onehot(match);
  assign miss    = req && !hit;
  assign rd_data = hit ? data_q[hit_way][req_set][req_word] : '0;

  // One LRU unit serves the request set in IDLE and the latched set while finishing a refill.
  assign lru_set = (state_q == IDLE) ? req_set : lset_q;
  assign lru_way = (state_q == IDLE) ? hit_way : victim_q;
  assign lru_upd = hit || (state_q == SWAP_IN_OK);

  dcache_lru #(
    .WAY_CNT (WAY_CNT),
    .AGE_W   (AGE_W),
    .WAY_W   (WAY_W)
  ) u_lru (
    .age_i    (age_q[lru_set]),
    .valid_i  (valid_q[lru_set]),
    .way_i    (lru_way),
    .age_o    (lru_age),
    .victim_o (vic_way)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      victim_q   <= '0;
      ltag_q     <= '0;
      lset_q     <= '0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        age_q[s]   <= '0;
      end
    end else begin
      if (lru_upd) age_q[lru_set] <= lru_age;
      unique case (state_q)
        IDLE: begin
          if (hit && store) dirty_q[req_set][hit_way] <= 1'b1;
          if (miss) begin
            victim_q <= vic_way;
            ltag_q   <= req_tag;
            lset_q   <= req_set;
            cnt_q    <= '0;
            if (valid_q[req_set][vic_way] && dirty_q[req_set][vic_way]) begin
              state_q    <= SWAP_OUT;
              mem_wr_req <= 1'b1;
              mem_addr   <= mem_word_addr(32'(tag_q[vic_way][req_set]), 32'(req_set), 32'd0,
                                          SET_ADDR_LEN, LINE_ADDR_LEN);
              mem_wdata  <= data_q[vic_way][req_set][0];
            end else begin
              state_q    <= SWAP_IN;
              mem_rd_req <= 1'b1;
              mem_addr   <= mem_word_addr(32'(req_tag), 32'(req_set), 32'd0,
                                          SET_ADDR_LEN, LINE_ADDR_LEN);
            end
          end
        end
        SWAP_OUT: if (mem_ack) begin
          cnt_q <= cnt_d;
          if (cnt_q == LAST_WORD) begin
            state_q    <= SWAP_IN;
            mem_wr_req <= 1'b0;
            mem_rd_req <= 1'b1;
            mem_addr   <= mem_word_addr(32'(ltag_q), 32'(lset_q), 32'd0,
                                        SET_ADDR_LEN, LINE_ADDR_LEN);
          end else begin
            mem_addr  <= mem_word_addr(32'(tag_q[victim_q][lset_q]), 32'(lset_q), 32'(cnt_d),
                                       SET_ADDR_LEN, LINE_ADDR_LEN);
            mem_wdata <= data_q[victim_q][lset_q][cnt_d];
          end
        end
        SWAP_IN: if (mem_ack) begin
          cnt_q <= cnt_d;
          if (cnt_q == LAST_WORD) begin
            state_q    <= SWAP_IN_OK;
            mem_rd_req <= 1'b0;
          end else begin
            mem_addr <= mem_word_addr(32'(ltag_q), 32'(lset_q), 32'(cnt_d),
                                      SET_ADDR_LEN, LINE_ADDR_LEN);
          end
        end
        SWAP_IN_OK: begin
          valid_q[lset_q][victim_q] <= 1'b1;
          dirty_q[lset_q][victim_q] <= 1'b0;
          state_q                   <= IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (hit && store) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_req[b]) data_q[hit_way][req_set][req_word][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if ((state_q == SWAP_IN) && mem_ack) data_q[victim_q][lset_q][cnt_q] <= mem_rdata;
    if (state_q == SWAP_IN_OK) tag_q[victim_q][lset_q] <= ltag_q;
  end

endmodule

// File: tb/tb_dcache_setassoc.sv
// Directed bench for dcache_setassoc against a 3-cycle-ack pattern memory.
module tb_dcache_setassoc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [3:0]  wr_req = 4'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;
  xfer_t log_q[$];
  int    wcnt = 0;

  dcache_setassoc dut (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .miss       (miss),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Memory: acknowledges each word on the third cycle its request is seen.
  always @(posedge clk) begin
    if (rst) begin
      mem_ack <= 1'b0;
      wcnt    <= 0;
    end else if ((mem_rd_req || mem_wr_req) && !mem_ack) begin
      if (wcnt == 1) begin
        mem_ack   <= 1'b1;
        mem_rdata <= pat(mem_addr);
        wcnt      <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      mem_ack <= 1'b0;
      wcnt    <= 0;
    end
    if (!rst && mem_ack && (mem_rd_req || mem_wr_req))
      log_q.push_back('{wr: mem_wr_req, a: mem_addr, d: mem_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic rd, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, output int mc, output logic [31:0] rdat,
                        output logic rdq, output logic wrq);
    @(negedge clk);
    log_q.delete();
    rd_req = rd; wr_req = be; addr = a; wr_data = wd; mc = 0;
    #1;
    while (miss && mc < 500) begin
      mc++;
      @(negedge clk);
      #1;
    end
    rdat = rd_data; rdq = mem_rd_req; wrq = mem_wr_req;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 4'b0;
  endtask

  initial begin
    int          mc;
    logic [31:0] rdat;
    logic        rdq, wrq, found;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_miss", 32'(miss), 32'd0);
    chk("reset_mem_rd_req", 32'(mem_rd_req), 32'd0);
    chk("reset_mem_wr_req", 32'(mem_wr_req), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);

    // Cold load: 2 + 8*3 stall cycles, words 0x40..0x5C in order
    access(1'b1, 4'b0, 32'h40, 32'h0, mc, rdat, rdq, wrq);
    chk("cold_miss_cycles", 32'(mc), 32'd26);
    chk("cold_fill_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("cold_fill_is_read", 32'(log_q[i].wr), 32'd0);
      chk("cold_fill_addr", log_q[i].a, 32'h40 + 32'(4 * i));
    end
    chk("cold_rd_data", rdat, 32'hBEAF0040);

    access(1'b1, 4'b0, 32'h44, 32'h0, mc, rdat, rdq, wrq);
    chk("hit44_miss_cycles", 32'(mc), 32'd0);
    chk("hit44_rd_data", rdat, 32'hBEAB0044);
    chk("hit44_mem_rd_req", 32'(rdq), 32'd0);
    chk("hit44_mem_wr_req", 32'(wrq), 32'd0);
    chk("hit44_traffic", 32'(log_q.size()), 32'd0);

    // Byte-lane store hit, then merged read-back
    access(1'b0, 4'b0010, 32'h48, 32'hAABBCCDD, mc, rdat, rdq, wrq);
    chk("store48_miss_cycles", 32'(mc), 32'd0);
    chk("store48_traffic", 32'(log_q.size()), 32'd0);
    access(1'b1, 4'b0, 32'h48, 32'h0, mc, rdat, rdq, wrq);
    chk("load48_miss_cycles", 32'(mc), 32'd0);
    chk("load48_merged", rdat, 32'hBEA7CC48);

    // Set 0: dirty 0x000 is LRU when 0x100 arrives -> writeback then refill
    access(1'b0, 4'b1111, 32'h000, 32'h11223344, mc, rdat, rdq, wrq);
    chk("store000_miss_cycles", 32'(mc), 32'd26);
    access(1'b1, 4'b0, 32'h080, 32'h0, mc, rdat, rdq, wrq);
    chk("load080_miss_cycles", 32'(mc), 32'd26);
    chk("load080_no_writeback", 32'(log_q.size()), 32'd8);
    access(1'b1, 4'b0, 32'h100, 32'h0, mc, rdat, rdq, wrq);
    chk("evict_miss_cycles", 32'(mc), 32'd50);
    chk("evict_xfer_count", 32'(log_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      if (i < 8) begin
        chk("wb_is_write", 32'(log_q[i].wr), 32'd1);
        chk("wb_addr", log_q[i].a, 32'(4 * i));
        chk("wb_data", log_q[i].d, (i == 0) ? 32'h11223344 : pat(32'(4 * i)));
      end else begin
        chk("refill_is_read", 32'(log_q[i].wr), 32'd0);
        chk("refill_addr", log_q[i].a, 32'h100 + 32'(4 * (i - 8)));
      end
    end
    chk("evict_rd_data", rdat, 32'hBFEF0100);

    // Set 1: 0x020 re-touched, so clean 0x0A0 is the victim for 0x120
    access(1'b1, 4'b0, 32'h020, 32'h0, mc, rdat, rdq, wrq);
    chk("load020_miss_cycles", 32'(mc), 32'd26);
    access(1'b1, 4'b0, 32'h0A0, 32'h0, mc, rdat, rdq, wrq);
    chk("load0A0_miss_cycles", 32'(mc), 32'd26);
    access(1'b1, 4'b0, 32'h020, 32'h0, mc, rdat, rdq, wrq);
    chk("retouch020_hit", 32'(mc), 32'd0);
    chk("retouch020_data", rdat, 32'hBECF0020);
    access(1'b1, 4'b0, 32'h120, 32'h0, mc, rdat, rdq, wrq);
    chk("clean_evict_miss_cycles", 32'(mc), 32'd26);
    chk("clean_evict_xfers", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < log_q.size(); i++) chk("clean_evict_no_write", 32'(log_q[i].wr), 32'd0);
    chk("clean_evict_rd_data", rdat, 32'hBFCF0120);
    access(1'b1, 4'b0, 32'h020, 32'h0, mc, rdat, rdq, wrq);
    chk("survivor020_hit", 32'(mc), 32'd0);

    // Reset while refill word 3 is outstanding
    @(negedge clk);
    log_q.delete();
    rd_req = 1'b1; addr = 32'h1E0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1;
      if (mem_addr == 32'h1EC) found = 1'b1;
    end
    chk("midfill_reached_word3", 32'(found), 32'd1);
    rst = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_mem_rd_req", 32'(mem_rd_req), 32'd0);
    chk("midrst_mem_wr_req", 32'(mem_wr_req), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_miss", 32'(miss), 32'd0);
    rst = 1'b0;
    access(1'b1, 4'b0, 32'h1E0, 32'h0, mc, rdat, rdq, wrq);
    chk("reissue_miss_cycles", 32'(mc), 32'd26);
    chk("reissue_xfers", 32'(log_q.size()), 32'd8);
    if (log_q.size() > 0) chk("reissue_first_addr", log_q[0].a, 32'h1E0);
    chk("reissue_rd_data", rdat, 32'hBF0F01E0);
    access(1'b1, 4'b0, 32'h44, 32'h0, mc, rdat, rdq, wrq);
    chk("postrst_invalidated", 32'(mc), 32'd26);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
